// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for a 256x16 sync RAM, LED register and switch port; MEM_ARB_ERR_EN adds err/err_cnt.
// Latency: request seen in IDLE -> ack two cycles later (IDLE->ACCESS->RESP); masters hold cmd until ack, no other backpressure.
module mem_bus_arbiter #(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] LED_ADDR = 9'h100,
  parameter logic [AW-1:0] SW_ADDR  = 9'h140
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [2:0]    i_a_cmd,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_ack,
  output logic [DW-1:0] o_a_rdata,
  input  logic [2:0]    i_b_cmd,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_ack,
  output logic [DW-1:0] o_b_rdata,
  output logic [AW-2:0] o_ram_addr,
  output logic          o_ram_write,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_led_load,
  output logic [7:0]    o_led_data,
  input  logic [7:0]    i_sw_in,
`ifdef MEM_ARB_ERR_EN
  output logic          o_err,
  output logic [7:0]    o_err_cnt,
`endif
  output logic          o_busy
);

  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t        r_state;
  logic          r_last_b;
  logic          r_gnt_b;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic [AW-2:0] r_ram_addr;
  logic          r_ram_write;
  logic [DW-1:0] r_ram_din;
  logic          r_led_load;
  logic [7:0]    r_led_data;
  logic          r_busy;

  logic          w_a_req;
  logic          w_b_req;
  logic          w_pick_b;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_io;
  logic          w_is_sw;
  logic          w_is_led;
  logic [DW-1:0] w_rd_val;

  always_comb begin
    w_a_req     = (i_a_cmd == CMD_READ) || (i_a_cmd == CMD_WRITE);
    w_b_req     = (i_b_cmd == CMD_READ) || (i_b_cmd == CMD_WRITE);
    // On a tie the master that did not win last time is served.
    w_pick_b    = w_b_req && (!w_a_req || !r_last_b);
    w_sel_wr    = w_pick_b ? (i_b_cmd == CMD_WRITE) : (i_a_cmd == CMD_WRITE);
    w_sel_addr  = w_pick_b ? i_b_addr : i_a_addr;
    w_sel_wdata = w_pick_b ? i_b_wdata : i_a_wdata;
    w_io        = r_addr[AW-1];
    w_is_sw     = (r_addr == SW_ADDR);
    w_is_led    = (r_addr == LED_ADDR);
    w_rd_val    = '0;
    if (!w_io)
      w_rd_val = i_ram_dout;
    else if (w_is_sw)
      w_rd_val = {{(DW-8){1'b0}}, i_sw_in};
  end

`ifdef MEM_ARB_ERR_EN
  logic       r_err;
  logic [7:0] r_err_cnt;
  logic       w_err;

  always_comb begin
    w_err = w_io && ((!w_is_sw && !w_is_led) || (r_wr && w_is_sw));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_ACCESS && w_err) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF)
          r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_last_b    <= 1'b1;
      r_gnt_b     <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_ram_addr  <= '0;
      r_ram_write <= 1'b0;
      r_ram_din   <= '0;
      r_led_load  <= 1'b0;
      r_led_data  <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_ram_write <= 1'b0;
      r_led_load  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_a_req || w_b_req) begin
            r_state     <= S_ACCESS;
            r_busy      <= 1'b1;
            r_gnt_b     <= w_pick_b;
            r_last_b    <= w_pick_b;
            r_wr        <= w_sel_wr;
            r_addr      <= w_sel_addr;
            r_ram_addr  <= w_sel_addr[AW-2:0];
            r_ram_din   <= w_sel_wdata;
            r_led_data  <= w_sel_wdata[7:0];
            r_ram_write <= w_sel_wr && !w_sel_addr[AW-1];
            r_led_load  <= w_sel_wr && (w_sel_addr == LED_ADDR);
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          r_a_ack <= !r_gnt_b;
          r_b_ack <= r_gnt_b;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          // RAM data arrives this cycle, one cycle after the address was presented.
          if (!r_wr) begin
            if (r_gnt_b)
              r_b_rdata <= w_rd_val;
            else
              r_a_rdata <= w_rd_val;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_a_ack     = r_a_ack;
  assign o_b_ack     = r_b_ack;
  assign o_a_rdata   = r_a_rdata;
  assign o_b_rdata   = r_b_rdata;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_write = r_ram_write;
  assign o_ram_din   = r_ram_din;
  assign o_led_load  = r_led_load;
  assign o_led_data  = r_led_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle corner sequences, and randomized traffic vs a transaction-level model.
module tb_mem_bus_arbiter;

  localparam logic [2:0] NONE = 3'b001;
  localparam logic [2:0] RD   = 3'b010;
  localparam logic [2:0] WR   = 3'b100;
  localparam logic [8:0] LED  = 9'h100;
  localparam logic [8:0] SW   = 9'h140;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  a_cmd, b_cmd;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        led_load;
  logic [7:0]  led_data;
  logic [7:0]  sw_in;
  logic        busy;
`ifdef MEM_ARB_ERR_EN
  logic        err;
  logic [7:0]  err_cnt;
`endif

  mem_bus_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_cmd(a_cmd), .i_a_addr(a_addr), .i_a_wdata(a_wdata), .o_a_ack(a_ack), .o_a_rdata(a_rdata),
    .i_b_cmd(b_cmd), .i_b_addr(b_addr), .i_b_wdata(b_wdata), .o_b_ack(b_ack), .o_b_rdata(b_rdata),
    .o_ram_addr(ram_addr), .o_ram_write(ram_write), .o_ram_din(ram_din), .i_ram_dout(ram_dout),
    .o_led_load(led_load), .o_led_data(led_data), .i_sw_in(sw_in),
`ifdef MEM_ARB_ERR_EN
    .o_err(err), .o_err_cnt(err_cnt),
`endif
    .o_busy(busy)
  );

  // Synchronous 256x16 RAM attached to the arbiter, with a bench-side preload port.
  logic [15:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_dat;
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    else if (pre_we) mem[pre_addr] <= pre_dat;
    ram_dout <= mem[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] exp_ard, exp_brd;
  logic        mdl_last_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mdl_read(input logic [8:0] ad, input logic [7:0] s);
    if (!ad[8]) return ref_mem[ad[7:0]];
    if (ad == SW) return {8'h00, s};
    return 16'h0000;
  endfunction

  function automatic logic [8:0] rnd_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return {1'b0, 3'b000, 5'($urandom)};
      3:       return LED;
      4:       return SW;
      default: return {1'b1, 8'($urandom)};
    endcase
  endfunction

  function automatic logic [2:0] idle_code();
    logic [2:0] c;
    c = 3'($urandom);
    if (c == RD || c == WR) c = NONE;
    return c;
  endfunction

  typedef struct {
    bit          is_b;
    logic [2:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  sw;
    logic [15:0] exp_rd;
    bit          exp_ramwr;
    bit          exp_led;
  } vec_t;
  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    a_cmd = NONE; b_cmd = NONE; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; sw_in = '0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(i);
      pre_dat = (i == 5) ? 16'hBEEF : (16'h3C00 ^ (16'(i) * 16'h0101));
      ref_mem[i] = pre_dat;
    end
    @(negedge clk);
    pre_we = 1'b0;

    chk("rst_strobes", 32'({a_ack, b_ack, ram_write, led_load, busy}), 32'(0));
    chk("rst_a_rdata", 32'(a_rdata), 32'(0));
    chk("rst_b_rdata", 32'(b_rdata), 32'(0));
    chk("rst_ram_addr", 32'({ram_addr, led_data}), 32'(0));
    rst_n = 1'b1;
    exp_ard = 16'h0000; exp_brd = 16'h0000;
    @(negedge clk);

    vt[0] = '{1'b0, RD, 9'h005, 16'h0000, 8'h00, 16'hBEEF, 1'b0, 1'b0};
    vt[1] = '{1'b0, RD, SW,     16'h0000, 8'h5A, 16'h005A, 1'b0, 1'b0};
    vt[2] = '{1'b1, WR, LED,    16'h12C3, 8'h00, 16'h0000, 1'b0, 1'b1};
    vt[3] = '{1'b1, WR, 9'h033, 16'h1234, 8'h00, 16'h0000, 1'b1, 1'b0};
    vt[4] = '{1'b1, RD, 9'h033, 16'h0000, 8'h00, 16'h1234, 1'b0, 1'b0};
    vt[5] = '{1'b0, WR, 9'h1C0, 16'h7777, 8'h00, 16'h0000, 1'b0, 1'b0};
    vt[6] = '{1'b0, RD, 9'h1FF, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0};
    vt[7] = '{1'b1, RD, LED,    16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      if (vt[v].is_b) begin b_cmd = vt[v].cmd; b_addr = vt[v].addr; b_wdata = vt[v].wdata; end
      else            begin a_cmd = vt[v].cmd; a_addr = vt[v].addr; a_wdata = vt[v].wdata; end
      sw_in = vt[v].sw;
      @(negedge clk);
      chk($sformatf("v%0d_access", v), 32'({busy, a_ack, b_ack, ram_write, led_load}),
          32'({1'b1, 1'b0, 1'b0, vt[v].exp_ramwr, vt[v].exp_led}));
      if (vt[v].exp_ramwr) chk($sformatf("v%0d_ram_bus", v), 32'({ram_addr, ram_din}), 32'({vt[v].addr[7:0], vt[v].wdata}));
      if (vt[v].exp_led) chk($sformatf("v%0d_led_data", v), 32'(led_data), 32'(vt[v].wdata[7:0]));
      @(negedge clk);
      chk($sformatf("v%0d_ack", v), 32'({busy, a_ack, b_ack}), 32'({1'b1, !vt[v].is_b, vt[v].is_b}));
`ifdef MEM_ARB_ERR_EN
      chk($sformatf("v%0d_err", v), 32'(err),
          32'(vt[v].addr[8] && ((vt[v].addr != LED && vt[v].addr != SW) || (vt[v].cmd == WR && vt[v].addr == SW))));
`endif
      if (vt[v].is_b) b_cmd = NONE; else a_cmd = NONE;
      if (vt[v].cmd == RD) begin
        if (vt[v].is_b) exp_brd = vt[v].exp_rd; else exp_ard = vt[v].exp_rd;
      end else if (!vt[v].addr[8]) ref_mem[vt[v].addr[7:0]] = vt[v].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_rdata", v), 32'({a_rdata, b_rdata}), 32'({exp_ard, exp_brd}));
      chk($sformatf("v%0d_idle", v), 32'(busy), 32'(0));
    end
`ifdef MEM_ARB_ERR_EN
    chk("err_cnt", 32'(err_cnt), 32'(2));
`endif

    // Both masters write right after reset: A wins the first tie, B follows three cycles later.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ard = 16'h0000; exp_brd = 16'h0000;
    chk("rst2_rdata", 32'({a_rdata, b_rdata}), 32'(0));
    a_cmd = WR; a_addr = 9'h010; a_wdata = 16'hAAAA;
    b_cmd = WR; b_addr = 9'h011; b_wdata = 16'hBBBB;
    begin
      int fa, fb, ov, wa;
      fa = -1; fb = -1; ov = 0; wa = -1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (a_ack && b_ack) ov++;
        if (ram_write && ram_addr == 8'h10 && wa < 0) wa = c;
        if (a_ack) begin if (fa < 0) fa = c; a_cmd = NONE; end
        if (b_ack) begin if (fb < 0) fb = c; b_cmd = NONE; end
      end
      chk("tie_a_ack_cycle", 32'(fa), 32'(2));
      chk("tie_b_ack_cycle", 32'(fb), 32'(5));
      chk("tie_a_write_cycle", 32'(wa), 32'(1));
      chk("tie_ack_overlap", 32'(ov), 32'(0));
      chk("tie_mem", 32'({mem[16], mem[17]}), 32'({16'hAAAA, 16'hBBBB}));
      ref_mem[16] = 16'hAAAA; ref_mem[17] = 16'hBBBB;
    end

    // Continuous requests from both: grants alternate A,B,A,B.
    a_cmd = RD; a_addr = 9'h005;
    b_cmd = RD; b_addr = 9'h033;
    begin
      int n;
      logic [3:0] ord;
      n = 0; ord = '0;
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        if (a_ack || b_ack) begin n++; ord = {ord[2:0], b_ack}; end
      end
      chk("rr_ack_count", 32'(n), 32'(4));
      chk("rr_order", 32'(ord), 32'(4'b0101));
    end
    a_cmd = NONE; b_cmd = NONE;
    exp_ard = ref_mem[5]; exp_brd = ref_mem[8'h33];
    @(negedge clk);
    chk("rr_rdata", 32'({a_rdata, b_rdata}), 32'({exp_ard, exp_brd}));

    // Reset arriving in ACCESS of a RAM write cuts the write off at once.
    a_cmd = WR; a_addr = 9'h020; a_wdata = 16'h5555;
    @(negedge clk);
    chk("cut_write_before", 32'(ram_write), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("cut_write_async", 32'({ram_write, busy, a_ack, b_ack}), 32'(0));
    a_cmd = NONE;
    @(negedge clk);
    rst_n = 1'b1;
    chk("cut_mem_intact", 32'(mem[32]), 32'(ref_mem[32]));
    exp_ard = 16'h0000; exp_brd = 16'h0000;
    begin
      int acks;
      acks = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (a_ack || b_ack || busy) acks++;
      end
      chk("cut_no_ack", 32'(acks), 32'(0));
    end
    mdl_last_b = 1'b1;

    // Randomized traffic checked against a transaction-level model.
    begin
      bit pa, pb, gb;
      logic [2:0]  ca, cb, gc;
      logic [8:0]  ada, adb, ga;
      logic [15:0] wda, wdb, gw;
      pa = 0; pb = 0;
      ca = NONE; cb = NONE; ada = '0; adb = '0; wda = '0; wdb = '0;
      for (int t = 0; t < 300; t++) begin
        if (!pa && $urandom_range(0, 2) != 0) begin
          pa = 1; ca = ($urandom_range(0, 1) != 0) ? WR : RD; ada = rnd_addr(); wda = 16'($urandom);
        end
        if (!pb && $urandom_range(0, 2) != 0) begin
          pb = 1; cb = ($urandom_range(0, 1) != 0) ? WR : RD; adb = rnd_addr(); wdb = 16'($urandom);
        end
        if (pa) begin a_cmd = ca; a_addr = ada; a_wdata = wda; end else a_cmd = idle_code();
        if (pb) begin b_cmd = cb; b_addr = adb; b_wdata = wdb; end else b_cmd = idle_code();
        if (!pa && !pb) begin
          @(negedge clk);
          chk("rnd_idle", 32'({busy, a_ack, b_ack}), 32'(0));
          continue;
        end
        gb = pb && (!pa || !mdl_last_b);
        mdl_last_b = gb;
        gc = gb ? cb : ca; ga = gb ? adb : ada; gw = gb ? wdb : wda;
        @(negedge clk);
        chk("rnd_access", 32'({busy, a_ack, b_ack, ram_write, led_load}),
            32'({1'b1, 1'b0, 1'b0, (gc == WR) && !ga[8], (gc == WR) && (ga == LED)}));
        if (gc == WR && !ga[8]) chk("rnd_ram_bus", 32'({ram_addr, ram_din}), 32'({ga[7:0], gw}));
        if (gb) begin b_cmd = 3'($urandom); b_addr = 9'($urandom); b_wdata = 16'($urandom); end
        else    begin a_cmd = 3'($urandom); a_addr = 9'($urandom); a_wdata = 16'($urandom); end
        @(negedge clk);
        sw_in = 8'($urandom);
        chk("rnd_ack", 32'({a_ack, b_ack}), 32'({!gb, gb}));
        if (gc == RD) begin
          if (gb) exp_brd = mdl_read(ga, sw_in); else exp_ard = mdl_read(ga, sw_in);
        end else if (!ga[8]) ref_mem[ga[7:0]] = gw;
        if (gb) begin pb = 0; b_cmd = NONE; end else begin pa = 0; a_cmd = NONE; end
        @(negedge clk);
        chk("rnd_rdata", 32'({a_rdata, b_rdata}), 32'({exp_ard, exp_brd}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
